// File: rtl/mmio_pkg.sv
// Shared definitions for the MMIO interconnect: FSM encoding, error data and
// the default SoC address map.
package mmio_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [31:0] ERR_DATA_DEF = 32'hDEAD_BEEF;

    localparam logic [31:0] DRAM_BASE      = 32'h0000_0000;
    localparam logic [31:0] DRAM_MASK      = 32'hFFFF_0000;
    localparam logic [31:0] SWITCH_BASE    = 32'hFFFF_F070;
    localparam logic [31:0] LED_BASE       = 32'hFFFF_F060;
    localparam logic [31:0] LED_DIGIT_BASE = 32'hFFFF_F000;
    localparam logic [31:0] DEV_MASK       = 32'hFFFF_FFFC;

    // Slave order: 0 = DRAM, 1 = switch, 2 = led, 3 = led_digit.
    localparam int DEF_NSLV = 4;
    localparam logic [DEF_NSLV*32-1:0] DEF_SLV_BASE =
        {LED_DIGIT_BASE, LED_BASE, SWITCH_BASE, DRAM_BASE};
    localparam logic [DEF_NSLV*32-1:0] DEF_SLV_MASK =
        {DEV_MASK, DEV_MASK, DEV_MASK, DRAM_MASK};

endpackage

// File: rtl/mmio_decode.sv
// Combinational priority address decoder: one-hot hit of the lowest-index
// slave whose masked address matches its base.
module mmio_decode #(
    parameter int                 NSLV     = 4,
    parameter int                 AW       = 32,
    parameter logic [NSLV*AW-1:0] SLV_BASE = '0,
    parameter logic [NSLV*AW-1:0] SLV_MASK = '0
) (
    input  logic [AW-1:0]   addr,
    output logic [NSLV-1:0] hit,
    output logic            hit_valid
);

    // Scan from the top down so the lowest matching index is the last writer.
    always_comb begin
        hit       = '0;
        hit_valid = 1'b0;
        for (int i = NSLV - 1; i >= 0; i--) begin
            if ((addr & SLV_MASK[i*AW +: AW]) == SLV_BASE[i*AW +: AW]) begin
                hit       = '0;
                hit[i]    = 1'b1;
                hit_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mmio_bus.sv
// MMIO interconnect: CPU req -> address decode -> slave req/ack with wait
// states, timeout error response and saturating error counter.
module mmio_bus
    import mmio_pkg::*;
#(
    parameter int                 NSLV     = 4,
    parameter int                 AW       = 32,
    parameter int                 DW       = 32,
    parameter logic [NSLV*AW-1:0] SLV_BASE = DEF_SLV_BASE,
    parameter logic [NSLV*AW-1:0] SLV_MASK = DEF_SLV_MASK,
    parameter int                 TIMEOUT  = 15,
    parameter logic [DW-1:0]      ERR_DATA = ERR_DATA_DEF
) (
    input  logic              clk,
    input  logic              rst_i,
    input  logic              m_req,
    input  logic              m_we,
    input  logic [AW-1:0]     m_addr,
    input  logic [DW-1:0]     m_wdata,
    output logic              m_ready,
    output logic [DW-1:0]     m_rdata,
    output logic              m_err,
    output logic [NSLV-1:0]   s_sel,
    output logic              s_we,
    output logic [AW-1:0]     s_addr,
    output logic [DW-1:0]     s_wdata,
    input  logic [NSLV-1:0]   s_ack,
    input  logic [NSLV*DW-1:0] s_rdata,
    output logic [7:0]        err_cnt,
    output logic [1:0]        dbg_state
);

    localparam logic [7:0] TO_VAL = 8'(TIMEOUT);

    logic [1:0]      state_q,   state_d;
    logic [7:0]      wait_cnt_q, wait_cnt_d;
    logic            m_ready_q, m_ready_d;
    logic [DW-1:0]   m_rdata_q, m_rdata_d;
    logic            m_err_q,   m_err_d;
    logic [NSLV-1:0] s_sel_q,   s_sel_d;
    logic            s_we_q,    s_we_d;
    logic [AW-1:0]   s_addr_q,  s_addr_d;
    logic [DW-1:0]   s_wdata_q, s_wdata_d;
    logic [7:0]      err_cnt_q, err_cnt_d;

    logic [NSLV-1:0] dec_hit;
    logic            dec_valid;
    logic [AW-1:0]   dec_off;
    logic [DW-1:0]   sel_rdata;
    logic            sel_ack;

    mmio_decode #(
        .NSLV     (NSLV),
        .AW       (AW),
        .SLV_BASE (SLV_BASE),
        .SLV_MASK (SLV_MASK)
    ) u_decode (
        .addr      (m_addr),
        .hit       (dec_hit),
        .hit_valid (dec_valid)
    );

    always_comb begin
        dec_off   = '0;
        sel_rdata = '0;
        for (int i = 0; i < NSLV; i++) begin
            if (dec_hit[i]) dec_off = m_addr & ~SLV_MASK[i*AW +: AW];
            if (s_sel_q[i]) sel_rdata = sel_rdata | s_rdata[i*DW +: DW];
        end
        sel_ack = |(s_ack & s_sel_q);
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        m_ready_d  = m_ready_q;
        m_rdata_d  = m_rdata_q;
        m_err_d    = m_err_q;
        s_sel_d    = s_sel_q;
        s_we_d     = s_we_q;
        s_addr_d   = s_addr_q;
        s_wdata_d  = s_wdata_q;
        err_cnt_d  = err_cnt_q;
        case (state_q)
            ST_IDLE: begin
                m_ready_d = 1'b0;
                m_err_d   = 1'b0;
                if (m_req) begin
                    if (dec_valid) begin
                        s_sel_d    = dec_hit;
                        s_we_d     = m_we;
                        s_addr_d   = dec_off;
                        s_wdata_d  = m_wdata;
                        wait_cnt_d = '0;
                        state_d    = ST_WAIT;
                    end else begin
                        // Unmapped: answer immediately, nothing reaches a slave.
                        m_err_d   = 1'b1;
                        m_rdata_d = ERR_DATA;
                        m_ready_d = 1'b1;
                        if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
                        state_d   = ST_RESP;
                    end
                end
            end
            ST_WAIT: begin
                wait_cnt_d = wait_cnt_q + 8'd1;
                // Ack wins over a timeout landing in the same cycle.
                if (sel_ack) begin
                    s_sel_d   = '0;
                    s_we_d    = 1'b0;
                    m_rdata_d = s_we_q ? '0 : sel_rdata;
                    m_err_d   = 1'b0;
                    m_ready_d = 1'b1;
                    state_d   = ST_RESP;
                end else if (wait_cnt_d == TO_VAL) begin
                    s_sel_d   = '0;
                    s_we_d    = 1'b0;
                    m_rdata_d = ERR_DATA;
                    m_err_d   = 1'b1;
                    m_ready_d = 1'b1;
                    if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
                    state_d   = ST_RESP;
                end
            end
            ST_RESP: begin
                m_ready_d = 1'b0;
                m_err_d   = 1'b0;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= '0;
            m_ready_q  <= 1'b0;
            m_rdata_q  <= '0;
            m_err_q    <= 1'b0;
            s_sel_q    <= '0;
            s_we_q     <= 1'b0;
            s_addr_q   <= '0;
            s_wdata_q  <= '0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            m_ready_q  <= m_ready_d;
            m_rdata_q  <= m_rdata_d;
            m_err_q    <= m_err_d;
            s_sel_q    <= s_sel_d;
            s_we_q     <= s_we_d;
            s_addr_q   <= s_addr_d;
            s_wdata_q  <= s_wdata_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign m_ready   = m_ready_q;
    assign m_rdata   = m_rdata_q;
    assign m_err     = m_err_q;
    assign s_sel     = s_sel_q;
    assign s_we      = s_we_q;
    assign s_addr    = s_addr_q;
    assign s_wdata   = s_wdata_q;
    assign err_cnt   = err_cnt_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mmio_bus.sv
// Bench for mmio_bus: per-transaction timeline model of the expected outputs,
// per-cycle compare, response queue and literal checks for the directed cases.
module tb_mmio_bus;

    localparam int NSLV = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TIMEOUT = 15;
    localparam logic [31:0] ERR = 32'hDEAD_BEEF;
    // led_digit decodes a whole 256-byte page, overlapping switch and led.
    localparam logic [NSLV*AW-1:0] TB_BASE =
        {32'hFFFF_F000, 32'hFFFF_F060, 32'hFFFF_F070, 32'h0000_0000};
    localparam logic [NSLV*AW-1:0] TB_MASK =
        {32'hFFFF_FF00, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'hFFFF_0000};

    logic              clk = 1'b0;
    logic              rst_i;
    logic              m_req;
    logic              m_we;
    logic [AW-1:0]     m_addr;
    logic [DW-1:0]     m_wdata;
    logic              m_ready;
    logic [DW-1:0]     m_rdata;
    logic              m_err;
    logic [NSLV-1:0]   s_sel;
    logic              s_we;
    logic [AW-1:0]     s_addr;
    logic [DW-1:0]     s_wdata;
    logic [NSLV-1:0]   s_ack;
    logic [NSLV*DW-1:0] s_rdata;
    logic [7:0]        err_cnt;
    logic [1:0]        dbg_state;

    mmio_bus #(
        .NSLV(NSLV), .AW(AW), .DW(DW),
        .SLV_BASE(TB_BASE), .SLV_MASK(TB_MASK),
        .TIMEOUT(TIMEOUT), .ERR_DATA(ERR)
    ) dut (
        .clk(clk), .rst_i(rst_i),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_ready(m_ready), .m_rdata(m_rdata), .m_err(m_err),
        .s_sel(s_sel), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_ack(s_ack), .s_rdata(s_rdata), .err_cnt(err_cnt),
        .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- model state ----------------
    logic [31:0] base_a [NSLV] = '{32'h0000_0000, 32'hFFFF_F070, 32'hFFFF_F060, 32'hFFFF_F000};
    logic [31:0] mask_a [NSLV] = '{32'hFFFF_0000, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'hFFFF_FF00};

    logic            exp_ready, exp_err, exp_we;
    logic [DW-1:0]   exp_rdata, exp_wdata;
    logic [AW-1:0]   exp_addr;
    logic [NSLV-1:0] exp_sel;
    int              exp_cnt;
    logic [DW:0]     exp_q[$];
    logic            check_en;

    int errors = 0;
    int checks = 0;

    int          obs_lat;
    logic        obs_err, obs_we;
    logic [31:0] obs_rdata, obs_addr, obs_wdata;
    logic [3:0]  obs_sel;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_target(input logic [31:0] addr);
        for (int i = 0; i < NSLV; i++)
            if ((addr & mask_a[i]) == base_a[i]) return i;
        return -1;
    endfunction

    function automatic void model_error();
        exp_ready = 1'b1;
        exp_err   = 1'b1;
        exp_rdata = ERR;
        exp_sel   = '0;
        exp_we    = 1'b0;
        if (exp_cnt < 255) exp_cnt++;
        exp_q.push_back({1'b1, ERR});
    endfunction

    // ---------------- scoreboard / compare ----------------
    always @(negedge clk) begin
        logic [DW:0] r;
        if (check_en) begin
            chk("m_ready", 32'(m_ready), 32'(exp_ready));
            chk("m_err", 32'(m_err), 32'(exp_err));
            chk("m_rdata", m_rdata, exp_rdata);
            chk("s_sel", 32'(s_sel), 32'(exp_sel));
            chk("err_cnt", 32'(err_cnt), 32'(exp_cnt));
            if (exp_sel != '0) begin
                chk("s_we", 32'(s_we), 32'(exp_we));
                chk("s_addr", s_addr, exp_addr);
                chk("s_wdata", s_wdata, exp_wdata);
            end
            if (m_ready) begin
                if (exp_q.size() == 0) begin
                    chk("resp_unexpected", 32'(m_ready), 32'd0);
                end else begin
                    r = exp_q.pop_front();
                    chk("resp_err", 32'(m_err), 32'(r[DW]));
                    chk("resp_data", m_rdata, r[DW-1:0]);
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic note_resp(input int edge_no);
        if (m_ready && obs_lat == 0) begin
            obs_lat   = edge_no;
            obs_err   = m_err;
            obs_rdata = m_rdata;
        end
    endtask

    // ack_at: WAIT cycle in which the target acks (0 = never; > TIMEOUT = late).
    task automatic do_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input int ack_at, input logic [31:0] rdat);
        int tgt, k, m;
        logic [3:0] tbit;
        tgt = model_target(addr);
        obs_lat = 0;
        m_req = 1'b1; m_we = we; m_addr = addr; m_wdata = wdata;
        @(posedge clk); #1;
        m_req = 1'b0; m_addr = $urandom; m_wdata = $urandom; m_we = 1'($urandom_range(0, 1));
        obs_sel = s_sel; obs_we = s_we; obs_addr = s_addr; obs_wdata = s_wdata;
        note_resp(1);
        k = 1;
        if (tgt < 0) begin
            model_error();
            k = 1;
        end else begin
            tbit      = 4'b0001 << tgt;
            exp_sel   = tbit;
            exp_we    = we;
            exp_addr  = addr & ~mask_a[tgt];
            exp_wdata = wdata;
            while (k <= TIMEOUT) begin
                s_ack   = 4'($urandom_range(0, 15)) & ~tbit;
                s_rdata = {$urandom, $urandom, $urandom, $urandom};
                if (k == ack_at) begin
                    s_ack = s_ack | tbit;
                    s_rdata[tgt*DW +: DW] = rdat;
                end
                @(posedge clk); #1;
                s_ack = '0;
                note_resp(k + 1);
                if (k == ack_at) begin
                    exp_ready = 1'b1; exp_err = 1'b0;
                    exp_rdata = we ? 32'h0 : rdat;
                    exp_sel = '0; exp_we = 1'b0;
                    exp_q.push_back({1'b0, exp_rdata});
                    k++;
                    break;
                end else if (k == TIMEOUT) begin
                    model_error();
                end
                k++;
            end
        end
        // k is now the RESP cycle; requests there must be ignored, late acks too.
        m = k;
        do begin
            if (m == k) begin
                m_req = 1'b1; m_addr = ($urandom_range(0, 1) == 1) ? 32'h0000_0040 : 32'h9000_0000;
            end
            if (tgt >= 0 && m == ack_at) begin
                s_ack[tgt] = 1'b1;
                s_rdata[tgt*DW +: DW] = rdat;
            end
            @(posedge clk); #1;
            s_ack = '0; m_req = 1'b0;
            if (m == k) begin
                exp_ready = 1'b0; exp_err = 1'b0;
            end
            m++;
        end while (m <= ack_at);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 4))
            0: return {16'h0000, 16'($urandom)};
            1: return 32'hFFFF_F070 | 32'($urandom_range(0, 3));
            2: return 32'hFFFF_F060 | 32'($urandom_range(0, 3));
            3: return 32'hFFFF_F000 | 32'($urandom_range(0, 255));
            default: return 32'h4000_0000 | 32'($urandom_range(0, 32'h0FFF_FFFF));
        endcase
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        int ack_at, r;
        rst_i = 1'b1; m_req = 1'b0; m_we = 1'b0; m_addr = '0; m_wdata = '0;
        s_ack = '0; s_rdata = '0; check_en = 1'b0;
        exp_ready = 0; exp_err = 0; exp_we = 0; exp_rdata = 0; exp_wdata = 0;
        exp_addr = 0; exp_sel = 0; exp_cnt = 0;

        @(posedge clk); #1;
        chk("rst_m_ready", 32'(m_ready), 32'd0);
        chk("rst_m_rdata", m_rdata, 32'd0);
        chk("rst_s_sel", 32'(s_sel), 32'd0);
        chk("rst_s_addr", s_addr, 32'd0);
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);
        chk("rst_state", 32'(dbg_state), 32'd0);
        @(posedge clk); #1;
        rst_i = 1'b0;
        check_en = 1'b1;
        idle(1);

        // led write, ack in first WAIT cycle
        do_txn(1'b1, 32'hFFFF_F060, 32'h1234_5678, 1, 32'h0);
        chk("led_sel", 32'(obs_sel), 32'h4);
        chk("led_we", 32'(obs_we), 32'd1);
        chk("led_wdata", obs_wdata, 32'h1234_5678);
        chk("led_lat", obs_lat, 32'd2);
        chk("led_err", 32'(obs_err), 32'd0);

        // DRAM read, ack after 3 wait cycles
        do_txn(1'b0, 32'h0000_0010, 32'h0, 3, 32'hCAFE_0001);
        chk("dram_addr", obs_addr, 32'h10);
        chk("dram_lat", obs_lat, 32'd4);
        chk("dram_rdata", obs_rdata, 32'hCAFE_0001);

        // unmapped read
        do_txn(1'b0, 32'h8000_0000, 32'h0, 1, 32'h0);
        chk("unmap_sel", 32'(obs_sel), 32'd0);
        chk("unmap_lat", obs_lat, 32'd1);
        chk("unmap_err", 32'(obs_err), 32'd1);
        chk("unmap_rdata", obs_rdata, 32'hDEAD_BEEF);
        chk("unmap_cnt", 32'(err_cnt), 32'd1);

        // switch timeout (overlaps led_digit, lowest index wins), late ack at 20
        do_txn(1'b0, 32'hFFFF_F070, 32'h0, 20, 32'h5555_AAAA);
        chk("to_sel", 32'(obs_sel), 32'h2);
        chk("to_lat", obs_lat, 32'(TIMEOUT + 1));
        chk("to_err", 32'(obs_err), 32'd1);
        chk("to_rdata", obs_rdata, 32'hDEAD_BEEF);
        chk("to_cnt", 32'(err_cnt), 32'd2);

        // ack coincident with timeout is a normal completion
        do_txn(1'b0, 32'hFFFF_F000, 32'h0, TIMEOUT, 32'h0000_7777);
        chk("edge_lat", obs_lat, 32'(TIMEOUT + 1));
        chk("edge_err", 32'(obs_err), 32'd0);
        chk("edge_rdata", obs_rdata, 32'h0000_7777);

        // randomized traffic
        for (int n = 0; n < 60; n++) begin
            r = $urandom_range(0, 9);
            if (r < 6)       ack_at = $urandom_range(1, 4);
            else if (r == 6) ack_at = TIMEOUT;
            else if (r == 7) ack_at = TIMEOUT - 1;
            else if (r == 8) ack_at = $urandom_range(TIMEOUT + 1, TIMEOUT + 4);
            else             ack_at = 0;
            do_txn(1'($urandom_range(0, 1)), rand_addr(), $urandom, ack_at, $urandom);
            idle($urandom_range(0, 2));
        end

        // saturate the error counter
        for (int n = 0; n < 300; n++)
            do_txn(1'($urandom_range(0, 1)), 32'h8000_0000 | 32'($urandom_range(0, 255)), $urandom, 1, 32'h0);
        chk("sat_cnt", 32'(err_cnt), 32'd255);

        // reset in the middle of a WAIT
        m_req = 1'b1; m_we = 1'b0; m_addr = 32'h0000_0020; m_wdata = 32'h0;
        @(posedge clk); #1;
        m_req = 1'b0;
        exp_sel = 4'b0001; exp_we = 1'b0; exp_addr = 32'h20; exp_wdata = 32'h0;
        idle(2);
        #2;
        rst_i = 1'b1;
        exp_ready = 0; exp_err = 0; exp_rdata = 0; exp_sel = 0; exp_we = 0; exp_cnt = 0;
        #1;
        chk("arst_sel", 32'(s_sel), 32'd0);
        chk("arst_ready", 32'(m_ready), 32'd0);
        chk("arst_cnt", 32'(err_cnt), 32'd0);
        chk("arst_state", 32'(dbg_state), 32'd0);
        chk("arst_pending", exp_q.size(), 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_i = 1'b0;
        idle(2);
        do_txn(1'b0, 32'h0000_0024, 32'h0, 2, 32'h0BAD_F00D);
        chk("post_addr", obs_addr, 32'h24);
        chk("post_lat", obs_lat, 32'd3);
        chk("post_rdata", obs_rdata, 32'h0BAD_F00D);
        idle(2);

        check_en = 1'b0;
        chk("queue_empty", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mmio_bus.md
Name: mmio_bus

Overview:
- Parametrised memory-mapped I/O interconnect between the CPU data port and NSLV peripheral or memory slaves (DRAM, led, led_digit, switch, future devices).
- Generalises the fixed single-cycle address decoder to a configurable address map with a req/ack handshake, so slaves may insert wait states.
- Adds a timeout with an error response and a saturating error counter.
- Sits between cpu_top and the peripherals inside the SoC top level.

Parameters:
- NSLV, 4, number of slave channels (1..8).
- AW, 32, address width.
- DW, 32, data width.
- SLV_BASE, {NSLV x AW} packed, base address of each slave; slave i occupies bits [i*AW +: AW].
- SLV_MASK, {NSLV x AW} packed, decode mask of each slave; slave i is hit when (addr & mask_i) == base_i.
- TIMEOUT, 15, maximum number of wait cycles before an error response (1..255).
- ERR_DATA, 32'hDEAD_BEEF, read data returned on an error.

Ports:
- clk  in  1  system clock, rising edge.
- rst_i  in  1  asynchronous active-high reset.
- m_req  in  1  CPU access request; sampled only in IDLE.
- m_we  in  1  1 = write, 0 = read.
- m_addr  in  AW  CPU address.
- m_wdata  in  DW  CPU write data.
- m_ready  out  1  one-cycle completion pulse.
- m_rdata  out  DW  read data; valid while m_ready = 1.
- m_err  out  1  error flag; valid while m_ready = 1.
- s_sel  out  NSLV  one-hot slave select, held until ack.
- s_we  out  1  write enable to the selected slave.
- s_addr  out  AW  address offset, equal to m_addr & ~mask_i.
- s_wdata  out  DW  write data to the selected slave.
- s_ack  in  NSLV  per-slave completion, one cycle.
- s_rdata  in  NSLV*DW  per-slave read data, valid with ack; slave i at [i*DW +: DW].
- err_cnt  out  8  saturating count of error responses.

Behaviour:
- Reset is asynchronous and active-high.
  - All outputs go to 0: m_ready, m_rdata, m_err, s_sel, s_we, s_addr, s_wdata, err_cnt.
  - FSM goes to IDLE; the wait counter is cleared.
  - Asserting reset mid-transaction aborts it; no m_ready is produced for the aborted access.
- All outputs are registered.
- FSM states: IDLE, WAIT, RESP.
- IDLE with m_req = 1:
  - Decode the address; if several slaves hit, the lowest index wins.
  - Hit: register s_sel = one-hot(i), s_we, s_addr, s_wdata; go to WAIT.
  - No hit: register m_err = 1, m_rdata = ERR_DATA, m_ready = 1; go to RESP. No slave is selected, so an unmapped write is dropped.
  - Unmapped latency is 1 cycle from request to m_ready.
- WAIT: the wait counter increments every cycle.
  - s_ack[i] = 1 for the selected i: clear s_sel and s_we; set m_rdata = s_rdata[i] (0 for writes), m_err = 0, m_ready = 1; go to RESP.
  - Ack bits from non-selected slaves are ignored.
  - Counter reaches TIMEOUT with no ack: clear s_sel; set m_rdata = ERR_DATA, m_err = 1, m_ready = 1; go to RESP.
  - An ack arriving in the same cycle as timeout is accepted as a normal completion with no error.
  - Latency: an ack in WAIT cycle k (k = 1 is the first WAIT cycle) gives m_ready at cycle k+1 after acceptance.
  - Minimum read latency is 2 cycles, with the ack in the first WAIT cycle.
- RESP: m_ready stays high for exactly this one cycle; then clear m_ready and m_err and return to IDLE.
  - m_rdata holds its value until the next response.
  - m_req is ignored in RESP, so back-to-back transactions are separated by at least one IDLE cycle.
- err_cnt increments on every error response (unmapped or timeout) and saturates at 255.
- s_addr and s_wdata stay stable for the whole time s_sel is asserted.
- Late acks arriving after a timeout are ignored.

Decomposition:
- Shared package mmio_pkg holds:
  - the FSM state encoding (IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2);
  - the ERR_DATA default;
  - the default SoC address-map constants: DRAM base 0x0000_0000 with mask 0xFFFF_0000; switch 0xFFFF_F070; led 0xFFFF_F060; led_digit 0xFFFF_F000; each device mask 0xFFFF_FFFC.
- One natural sub-module: mmio_decode, a combinational priority address decoder (address in, one-hot hit out plus a hit-valid flag).
- FSM, wait counter and response datapath stay in mmio_bus.

Test Plan:
- Write 0x1234_5678 to 0xFFFF_F060 with the led slave (index 2) acking in the first WAIT cycle -> s_sel = 4'b0100, s_we = 1, s_wdata = 0x1234_5678; m_ready pulses at cycle 2 with m_err = 0.
- Read 0x0000_0010 with DRAM (index 0) acking after 3 wait cycles with 0xCAFE_0001 -> s_addr = 0x10; m_ready at cycle 4, m_rdata = 0xCAFE_0001.
- Read 0x8000_0000 (unmapped) -> s_sel stays 0; m_ready at cycle 1 with m_err = 1, m_rdata = 0xDEAD_BEEF; err_cnt 0 -> 1.
- Read from the switch slave with no ack and TIMEOUT = 15 -> m_ready at WAIT count 15 with m_err = 1; s_sel dropped; an ack at cycle 20 is ignored.
- Overlapping map (slaves 1 and 3 both hit) -> s_sel = 4'b0010. Run 300 unmapped accesses -> err_cnt saturates at 255.
- Assert rst_i during WAIT -> outputs clear asynchronously with no m_ready. After release, a new read to DRAM completes normally.
